// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter granting one queued alloc_entry_t request at a time to the allocator core.
// Optional per-queue grant counters are enabled by defining FALAFEL_ARB_STATS_EN.

package falafel_pkg;
  localparam int unsigned MSG_ID_W = 4;
  localparam int unsigned DATA_W   = 8;

  typedef struct packed {
    logic [MSG_ID_W-1:0] msg_id;
    logic [DATA_W-1:0]   payload;
  } alloc_entry_t;
endpackage

module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
`ifdef FALAFEL_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic         [NUM_REQ-1:0]       req_val_i,
  output logic         [NUM_REQ-1:0]       req_rdy_o,
  input  alloc_entry_t [NUM_REQ-1:0]       req_data_i,
  output logic                             out_val_o,
  input  logic                             out_rdy_i,
  output alloc_entry_t                     out_data_o,
  output logic         [SRC_W-1:0]         out_src_o,
  input  logic                             done_i,
  output logic                             busy_o
`ifdef FALAFEL_ARB_STATS_EN
  ,
  output logic         [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             out_val_q, out_val_d;
  alloc_entry_t     out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [SRC_W-1:0] winner;
  alloc_entry_t     winner_data;
  logic             grant;

  // Rotating priority: prefer the lowest valid index at or above rr_ptr, else the lowest overall.
  always_comb begin
    logic             hi_found;
    logic [SRC_W-1:0] hi_idx;
    logic [SRC_W-1:0] lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    found    = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_val_i[i]) begin
        found  = 1'b1;
        lo_idx = SRC_W'(i);
        if (SRC_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SRC_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    winner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (SRC_W'(i) == winner) begin
        winner_data = req_data_i[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_ptr_d   = rr_ptr_q;
    grant      = 1'b0;
    req_rdy_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant      = 1'b1;
          out_val_d  = 1'b1;
          out_data_d = winner_data;
          out_src_d  = winner;
          rr_ptr_d   = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + SRC_W'(1);
          state_d    = ST_ISSUE;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_rdy_o[i] = rst_ni && (SRC_W'(i) == winner);
          end
        end
      end
      ST_ISSUE: begin
        if (out_rdy_i) begin
          out_val_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        out_val_d = 1'b0;
        if (done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        out_val_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign out_val_o  = out_val_q;
  assign out_data_o = out_data_q;
  assign out_src_o  = out_src_q;
  assign busy_o     = busy_q;

`ifdef FALAFEL_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-queue grant counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant && (SRC_W'(i) == winner) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed self-checking bench for falafel_req_arbiter (NUM_REQ=4).
module tb_falafel_req_arbiter;
  import falafel_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SRC_W   = 2;
`ifdef FALAFEL_ARB_STATS_EN
  localparam int unsigned CNT_W   = 2;
`endif

  logic                       clk_i;
  logic                       rst_ni;
  logic         [NUM_REQ-1:0] req_val_i;
  logic         [NUM_REQ-1:0] req_rdy_o;
  alloc_entry_t [NUM_REQ-1:0] req_data_i;
  logic                       out_val_o;
  logic                       out_rdy_i;
  alloc_entry_t               out_data_o;
  logic         [SRC_W-1:0]   out_src_o;
  logic                       done_i;
  logic                       busy_o;
`ifdef FALAFEL_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_o;
`endif

  int n_checks;
  int n_fails;

  falafel_req_arbiter #(
    .NUM_REQ(NUM_REQ),
    .SRC_W  (SRC_W)
`ifdef FALAFEL_ARB_STATS_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_val_i  (req_val_i),
    .req_rdy_o  (req_rdy_o),
    .req_data_i (req_data_i),
    .out_val_o  (out_val_o),
    .out_rdy_i  (out_rdy_i),
    .out_data_o (out_data_o),
    .out_src_o  (out_src_o),
    .done_i     (done_i),
    .busy_o     (busy_o)
`ifdef FALAFEL_ARB_STATS_EN
    ,
    .grant_cnt_o(grant_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete grant/accept/done transaction for queue q.
  task automatic do_txn(input int q);
    req_val_i = 4'(1 << q);
    tick();
    req_val_i = '0;
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    done_i    = 1'b1;
    tick();
    done_i    = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_ni    = 1'b0;
    req_val_i = '1;
    out_rdy_i = 1'b0;
    done_i    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_data_i[i] = {4'(i), 8'(8'h10 + i)};
    end

    // Reset state, ready suppressed while held in reset
    #2;
    chk("rst_rdy", 64'(req_rdy_o), 64'h0);
    chk("rst_val", 64'(out_val_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_src", 64'(out_src_o), 64'h0);
    chk("rst_data", 64'(out_data_o), 64'h0);
    tick();
    req_val_i = '0;
    rst_ni    = 1'b1;
    tick();

    // All queues valid: order 0,1,2,3,0, one grant per 3 cycles
    req_val_i = '1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_rdy", 64'(req_rdy_o), 64'(1 << (g % 4)));
      tick();
      out_rdy_i = 1'b1;
      #1;
      chk("rr_val", 64'(out_val_o), 64'h1);
      chk("rr_src", 64'(out_src_o), 64'(g % 4));
      chk("rr_data", 64'(out_data_o), 64'({4'(g % 4), 8'(8'h10 + (g % 4))}));
      chk("rr_issue_rdy", 64'(req_rdy_o), 64'h0);
      tick();
      out_rdy_i = 1'b0;
      done_i    = 1'b1;
      #1;
      chk("rr_wait_val", 64'(out_val_o), 64'h0);
      chk("rr_wait_busy", 64'(busy_o), 64'h1);
      chk("rr_wait_rdy", 64'(req_rdy_o), 64'h0);
      tick();
      done_i = 1'b0;
    end
    req_val_i = '0;
    tick();

    // Single requester 2 with payload A5
    req_data_i[2] = {4'h3, 8'hA5};
    req_val_i     = 4'b0100;
    #1;
    chk("t1_rdy", 64'(req_rdy_o), 64'h4);
    tick();
    req_val_i = '0;
    #1;
    chk("t1_val", 64'(out_val_o), 64'h1);
    chk("t1_src", 64'(out_src_o), 64'h2);
    chk("t1_data", 64'(out_data_o), 64'h3A5);
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    done_i    = 1'b1;
    tick();
    done_i = 1'b0;
    #1;
    chk("t1_idle_busy", 64'(busy_o), 64'h0);

    // done_i in IDLE without requests is ignored
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    #1;
    chk("t4_idle_busy", 64'(busy_o), 64'h0);
    chk("t4_idle_val", 64'(out_val_o), 64'h0);

    // Pointer now 3: queue 0 wins by wrap-around; then stall 5 cycles in ISSUE
    req_val_i = 4'b0001;
    #1;
    chk("t3_rdy", 64'(req_rdy_o), 64'h1);
    tick();
    req_val_i = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      done_i = (c == 2);
      #1;
      chk("t3_hold_val", 64'(out_val_o), 64'h1);
      chk("t3_hold_src", 64'(out_src_o), 64'h0);
      chk("t3_hold_data", 64'(out_data_o), 64'h010);
      chk("t3_hold_rdy", 64'(req_rdy_o), 64'h0);
      chk("t3_hold_busy", 64'(busy_o), 64'h1);
      tick();
    end
    done_i    = 1'b0;
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    #1;
    chk("t3_wait_val", 64'(out_val_o), 64'h0);
    chk("t3_wait_busy", 64'(busy_o), 64'h1);
    chk("t3_wait_rdy", 64'(req_rdy_o), 64'h0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;

    // Pointer now 1: valid 1,2,3 -> queue 1 next; instead use queue 2 alone, reset in WAIT
    req_val_i = 4'b0100;
    #1;
    chk("t5_rdy", 64'(req_rdy_o), 64'h4);
    tick();
    req_val_i = '0;
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    #1;
    chk("t5_wait_busy", 64'(busy_o), 64'h1);
    rst_ni    = 1'b0;
    req_val_i = 4'b1001;
    #1;
    chk("t5_rst_val", 64'(out_val_o), 64'h0);
    chk("t5_rst_busy", 64'(busy_o), 64'h0);
    chk("t5_rst_rdy", 64'(req_rdy_o), 64'h0);
    tick();
    rst_ni = 1'b1;
    done_i = 1'b1;
    #1;
    chk("t5_post_rdy", 64'(req_rdy_o), 64'h1);
    tick();
    done_i    = 1'b0;
    req_val_i = 4'b1000;
    #1;
    chk("t5_post_src", 64'(out_src_o), 64'h0);
    chk("t5_post_val", 64'(out_val_o), 64'h1);
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    done_i    = 1'b1;
    tick();
    done_i = 1'b0;
    #1;
    chk("t5_next_rdy", 64'(req_rdy_o), 64'h8);
    tick();
    req_val_i = '0;
    out_rdy_i = 1'b1;
    tick();
    out_rdy_i = 1'b0;
    done_i    = 1'b1;
    tick();
    done_i = 1'b0;

`ifdef FALAFEL_ARB_STATS_EN
    // Saturating counters with CNT_W=2
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("t6_rst_cnt", 64'(grant_cnt_o), 64'h0);
    for (int k = 0; k < 3; k++) do_txn(1);
    #1;
    chk("t6_cnt1_3", 64'(grant_cnt_o[1]), 64'h3);
    for (int k = 0; k < 2; k++) do_txn(1);
    #1;
    chk("t6_cnt1_sat", 64'(grant_cnt_o[1]), 64'h3);
    chk("t6_cnt0", 64'(grant_cnt_o[0]), 64'h0);
    chk("t6_cnt2", 64'(grant_cnt_o[2]), 64'h0);
    chk("t6_cnt3", 64'(grant_cnt_o[3]), 64'h0);
`else
    do_txn(1);
    #1;
    chk("t6_final_busy", 64'(busy_o), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
